// File: rtl/led_sched_pkg.sv
// Shared types and default timing constants for the LED event scheduler.
package led_sched_pkg;

  // Sequencer states: waiting, LED lit, forced dark gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_e;

  localparam int SYSTEM_CLOCK = 50000000;
  localparam int ON_DIV       = 8;
  localparam int GAP_DIV      = 16;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/led_event_sched_if.sv
// Event inputs and LED status outputs of the scheduler, grouped as one bundle.
interface led_event_sched_if #(
  parameter int N_SRC = 4
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0] evt;
  logic             led;
  logic [SRC_W-1:0] led_src;
  logic [N_SRC-1:0] pending;
  logic             busy;

  // Event producer side (board logic / bench).
  modport master (
    output evt,
    input  led,
    input  led_src,
    input  pending,
    input  busy
  );

  // Scheduler side.
  modport slave (
    input  evt,
    output led,
    output led_src,
    output pending,
    output busy
  );
endinterface

// File: rtl/evt_edge_sync.sv
// Per-source input conditioning: two-flop synchronizer, history flop and a
// registered rising-edge pulse.
module evt_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic evt_in,
  output logic edge_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic hist_r;
  logic edge_r;

  // Synchronize the asynchronous level, remember it, and flag a 0->1 change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= evt_in;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
      edge_r  <= sync2_r & ~hist_r;
    end
  end

  assign edge_pulse = edge_r;

endmodule

// File: rtl/led_event_sched.sv
// Time-shares one status LED among N_SRC event sources. Each event is held
// pending, granted round-robin, shown for ON_CLKS cycles and followed by a
// GAP_CLKS dark period so consecutive indications stay distinguishable.
module led_event_sched #(
  parameter int SYSTEM_CLOCK = led_sched_pkg::SYSTEM_CLOCK,
  parameter int N_SRC        = 4,
  parameter int ON_CLKS      = SYSTEM_CLOCK / led_sched_pkg::ON_DIV,
  parameter int GAP_CLKS     = SYSTEM_CLOCK / led_sched_pkg::GAP_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  led_event_sched_if.slave   bus
);
  import led_sched_pkg::*;

  localparam int SRC_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(max_int(ON_CLKS, GAP_CLKS)) + 1;

  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] clr_mask_s;
  logic [SRC_W-1:0] rr_ptr_r;
  logic [SRC_W-1:0] grant_idx_s;
  logic [SRC_W-1:0] rr_next_s;
  logic             grant_found_s;
  logic             grant_now_s;
  logic             on_done_s;
  logic             gap_done_s;
  logic [CNT_W-1:0] cnt_r;
  sched_state_e     state_r;
  logic             led_r;
  logic             busy_r;
  logic [SRC_W-1:0] led_src_r;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    evt_edge_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .evt_in     (bus.evt[i]),
      .edge_pulse (edge_s[i])
    );
  end

  // Round-robin search: first pending source at or after the RR pointer.
  always_comb begin
    int unsigned idx_v;
    idx_v         = 0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % N_SRC;
      if (!grant_found_s && pending_r[idx_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = SRC_W'(idx_v);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Phase-end flags, grant decision, pointer advance and pending clear mask.
  always_comb begin
    on_done_s   = (cnt_r == CNT_W'(ON_CLKS - 1));
    gap_done_s  = (cnt_r == CNT_W'(GAP_CLKS - 1));
    grant_now_s = 1'b0;
    if (grant_found_s) begin
      if (state_r == ST_IDLE) begin
        grant_now_s = 1'b1;
      end else if ((state_r == ST_GAP) && gap_done_s) begin
        grant_now_s = 1'b1;
      end else begin
        grant_now_s = 1'b0;
      end
    end else begin
      grant_now_s = 1'b0;
    end
    if (grant_idx_s == SRC_W'(N_SRC - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + SRC_W'(1);
    end
    if (grant_now_s) begin
      clr_mask_s = {{(N_SRC-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      clr_mask_s = '0;
    end
  end

  // Pending requests: a new edge wins over a same-cycle clear by its own grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | edge_s;
    end
  end

  // Grant sequencer: state, phase counter and all registered LED outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      led_r     <= 1'b0;
      busy_r    <= 1'b0;
      led_src_r <= '0;
      rr_ptr_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_now_s) begin
            state_r   <= ST_ON;
            cnt_r     <= '0;
            led_r     <= 1'b1;
            busy_r    <= 1'b1;
            led_src_r <= grant_idx_s;
            rr_ptr_r  <= rr_next_s;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end
        end
        ST_ON: begin
          if (on_done_s) begin
            state_r <= ST_GAP;
            cnt_r   <= '0;
            led_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_done_s) begin
            cnt_r <= '0;
            if (grant_now_s) begin
              state_r   <= ST_ON;
              led_r     <= 1'b1;
              led_src_r <= grant_idx_s;
              rr_ptr_r  <= rr_next_s;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          led_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led     = led_r;
  assign bus.busy    = busy_r;
  assign bus.led_src = led_src_r;
  assign bus.pending = pending_r;

endmodule

// File: tb/tb_led_event_sched.sv
// Self-checking bench for led_event_sched with N_SRC=4, ON_CLKS=8, GAP_CLKS=4.
module tb_led_event_sched;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   exp_q[$];

  led_event_sched_if #(.N_SRC(4)) bus ();

  led_event_sched #(
    .SYSTEM_CLOCK (50000000),
    .N_SRC        (4),
    .ON_CLKS      (8),
    .GAP_CLKS     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] evt_val);
    rst_n   = 1'b0;
    bus.evt = evt_val;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Waits for the next 0->1 transition of led; reports ticks and low samples.
  task automatic wait_led_rise(output bit ok, output int cycles, output int lows);
    bit seen_low;
    ok       = 1'b0;
    cycles   = 0;
    lows     = 0;
    seen_low = (bus.led == 1'b0);
    for (int k = 0; k < 200; k++) begin
      tick();
      cycles++;
      if (!bus.led) begin
        seen_low = 1'b1;
        lows++;
      end else if (seen_low) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard pop: next grant must show the oldest expected source.
  task automatic grant_check(input string name, output int cycles, output int lows);
    bit ok;
    int exp;
    wait_led_rise(ok, cycles, lows);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: led rise timeout, got none, required a grant", name);
    end else if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected grant of src %0d, required none", name, bus.led_src);
    end else begin
      exp = exp_q.pop_front();
      if (bus.led_src !== 2'(exp)) begin
        n_err++;
        $display("FAIL %s: led_src got %0d required %0d", name, bus.led_src, exp);
      end
    end
  endtask

  task automatic count_rises(input int n, output int rises);
    logic prev;
    rises = 0;
    prev  = bus.led;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.led && !prev) rises++;
      prev = bus.led;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.evt = 4'b0000;
    repeat (2) tick();
    n_vec++;
    if ({bus.led, bus.busy, bus.led_src, bus.pending} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_vals: got led=%b busy=%b src=%0d pend=%b required all 0",
               bus.led, bus.busy, bus.led_src, bus.pending);
    end
    apply_reset(4'b0000);
    repeat (10) tick();
    n_vec++;
    if ({bus.led, bus.busy, bus.pending} !== 6'b0) begin
      n_err++;
      $display("FAIL idle_quiet: got led=%b busy=%b pend=%b required 0", bus.led, bus.busy, bus.pending);
    end
  endtask

  task automatic test_single();
    int bad;
    apply_reset(4'b0000);
    bus.evt = 4'b0100;
    exp_q.push_back(2);
    tick();                       // P1: first sampling edge
    bus.evt = 4'b0000;
    tick(); tick();               // P3
    n_vec++;
    if (bus.pending !== 4'b0000) begin
      n_err++;
      $display("FAIL pend_early: got %b required 0000", bus.pending);
    end
    tick();                       // P4
    n_vec++;
    if (bus.pending !== 4'b0100 || bus.led !== 1'b0) begin
      n_err++;
      $display("FAIL pend_e3: got pend=%b led=%b required 0100/0", bus.pending, bus.led);
    end
    tick();                       // P5
    n_vec++;
    if (bus.led !== 1'b1 || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL led_e4: got led=%b required 1", bus.led);
    end else if (bus.led_src !== 2'(exp_q.pop_front())) begin
      n_err++;
      $display("FAIL src_e4: got %0d required 2", bus.led_src);
    end
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (bus.led !== 1'b1 || bus.busy !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL on_time: %0d off samples in ON, required 0", bad);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.led !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL gap_time: %0d bad samples in GAP, required 0", bad);
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.led !== 1'b0) begin
      n_err++;
      $display("FAIL back_idle: got busy=%b led=%b required 0/0", bus.busy, bus.led);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int l;
    apply_reset(4'b0000);
    bus.evt = 4'b1001;
    exp_q.push_back(0);
    exp_q.push_back(3);
    tick();
    bus.evt = 4'b0000;
    grant_check("b2b_first", c, l);
    grant_check("b2b_second", c, l);
    n_vec++;
    if (c != 12 || l != 4) begin
      n_err++;
      $display("FAIL b2b_period: got period=%0d gap=%0d required 12/4", c, l);
    end
  endtask

  task automatic test_round_robin();
    int c;
    int l;
    apply_reset(4'b0000);
    bus.evt = 4'b0010;
    exp_q.push_back(1);
    tick();
    bus.evt = 4'b0000;
    grant_check("rr_first", c, l);
    bus.evt = 4'b0101;
    exp_q.push_back(2);
    exp_q.push_back(0);
    tick();
    bus.evt = 4'b0000;
    grant_check("rr_after1", c, l);
    grant_check("rr_wrap", c, l);
  endtask

  task automatic test_collapse();
    int c;
    int l;
    int r;
    apply_reset(4'b0000);
    bus.evt = 4'b0010;
    exp_q.push_back(1);
    tick();
    bus.evt = 4'b0000;
    grant_check("col_first", c, l);
    exp_q.push_back(1);
    for (int k = 0; k < 3; k++) begin
      bus.evt = 4'b0010;
      tick();
      bus.evt = 4'b0000;
      tick();
    end
    grant_check("col_again", c, l);
    n_vec++;
    if (c + 6 != 12) begin
      n_err++;
      $display("FAIL col_period: got %0d required 12", c + 6);
    end
    count_rises(40, r);
    n_vec++;
    if (r != 0 || bus.busy !== 1'b0 || bus.pending !== 4'b0000) begin
      n_err++;
      $display("FAIL col_once: got rises=%0d busy=%b pend=%b required 0/0/0000", r, bus.busy, bus.pending);
    end
  endtask

  task automatic test_reset_mid_grant();
    int c;
    int l;
    int r;
    apply_reset(4'b0000);
    bus.evt = 4'b0001;
    exp_q.push_back(0);
    tick();
    bus.evt = 4'b0000;
    grant_check("rst_grant", c, l);
    bus.evt = 4'b0101;
    tick();
    bus.evt = 4'b0000;
    repeat (4) tick();
    n_vec++;
    if (bus.pending !== 4'b0101 || bus.led !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: got pend=%b led=%b required 0101/1", bus.pending, bus.led);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.led !== 1'b0 || bus.pending !== 4'b0000 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got led=%b pend=%b busy=%b required 0/0000/0", bus.led, bus.pending, bus.busy);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    count_rises(40, r);
    n_vec++;
    if (r != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_discard: got rises=%0d busy=%b required 0/0", r, bus.busy);
    end
  endtask

  task automatic test_held_at_reset();
    int c;
    int l;
    int r;
    apply_reset(4'b1000);
    exp_q.push_back(3);
    grant_check("held_grant", c, l);
    count_rises(40, r);
    n_vec++;
    if (r != 0 || bus.busy !== 1'b0 || bus.pending !== 4'b0000) begin
      n_err++;
      $display("FAIL held_once: got rises=%0d busy=%b pend=%b required 0/0/0000", r, bus.busy, bus.pending);
    end
    bus.evt = 4'b0000;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    bus.evt = 4'b0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_collapse();
    test_reset_mid_grant();
    test_held_at_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left: got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
